// File: rtl/zbuf_pkg.sv
// Shared Z-buffer package: span FSM states, default geometry/widths and the
// linear frame/Z-buffer address function used by the span and edge blocks.
package zbuf_pkg;

  localparam int X_W_D    = 10;
  localparam int Y_W_D    = 9;
  localparam int Z_W_D    = 16;
  localparam int C_W_D    = 24;
  localparam int H_RES_D  = 640;
  localparam int FRAC_D   = 8;
  localparam int ADDR_W_D = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORDER,
    S_DIV,
    S_READ,
    S_CMP
  } span_st_e;

  // Row-major pixel address.
  function automatic logic [31:0] line_addr(input logic [31:0] y,
                                            input logic [31:0] x,
                                            input logic [31:0] h_res);
    return y * h_res + x;
  endfunction

endpackage

// File: rtl/span_div.sv
// Restoring unsigned divider, one quotient bit per cycle, N cycles per divide.
// Ports:
//   clk, rst (async, active low)
//   start     load dividend/divisor and begin
//   dividend  N-bit numerator
//   divisor   D-bit denominator, never 0
//   quotient  valid while done is high (held afterwards)
//   done      one-cycle pulse after the last quotient bit
module span_div #(
  parameter int N = 24,
  parameter int D = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  q_q;
  logic [D-1:0]  rem_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic [D:0]    rem_sh;
  logic          fits;

  // Dividend bits shift out of q_q's MSB while quotient bits shift in at LSB.
  assign rem_sh = {rem_q, q_q[N-1]};
  assign fits   = rem_sh >= {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        q_q    <= dividend;
        rem_q  <= '0;
        dvs_q  <= divisor;
        cnt_q  <= CW'(N - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        q_q   <= {q_q[N-2:0], fits};
        // Remainder stays below the divisor, so the top bit is always 0.
        rem_q <= fits ? D'(rem_sh - {1'b0, dvs_q}) : rem_sh[D-1:0];
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign quotient = q_q;
  assign done     = done_q;

endmodule

// File: rtl/span_fill.sv
// Span rasteriser: fills x in [min(x_a,x_b), max(x_a,x_b)] on scanline y with
// linearly interpolated depth, Z-tests each pixel against the Z-buffer and
// writes depth + flat colour where the new depth is strictly nearer.
// Ports:
//   clk, rst (async, active low)
//   req / ack            fill request (sampled in IDLE) / span busy
//   x_a,x_b,z_a,z_b,y,color  span description, stable only while req=1
//   zb_rd_en, zb_addr, zb_rdata   Z-buffer read (data one cycle later)
//   zb_wr_en, zb_wdata            Z-buffer write (shares zb_addr)
//   pix_we, pix_addr, pix_color   frame-buffer write
module span_fill
  import zbuf_pkg::*;
#(
  parameter int X_W    = X_W_D,
  parameter int Y_W    = Y_W_D,
  parameter int Z_W    = Z_W_D,
  parameter int C_W    = C_W_D,
  parameter int H_RES  = H_RES_D,
  parameter int FRAC   = FRAC_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ack,
  input  logic [X_W-1:0]    x_a,
  input  logic [X_W-1:0]    x_b,
  input  logic [Z_W-1:0]    z_a,
  input  logic [Z_W-1:0]    z_b,
  input  logic [Y_W-1:0]    y,
  input  logic [C_W-1:0]    color,
  output logic              zb_rd_en,
  output logic [ADDR_W-1:0] zb_addr,
  input  logic [Z_W-1:0]    zb_rdata,
  output logic              zb_wr_en,
  output logic [Z_W-1:0]    zb_wdata,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [C_W-1:0]    pix_color
);

  localparam int N = Z_W + FRAC;

  span_st_e          state_q;
  logic [X_W-1:0]    xa_q, xb_q, x_q, xr_q;
  logic [Z_W-1:0]    za_q, zb_q;
  logic [Y_W-1:0]    y_q;
  logic [C_W-1:0]    col_q;
  logic              neg_q, ack_q, rd_q;
  logic [N:0]        z_acc_q, slope_q;
  logic [ADDR_W-1:0] addr_q;

  // Endpoint ordering, evaluated from the latched request during ORDER.
  logic              swap, dz_neg, div_start, div_done, wr_hit;
  logic [X_W-1:0]    xl, xr, dx;
  logic [Z_W-1:0]    zl, zr, dz_mag, z_pix;
  logic [N-1:0]      div_q;
  logic [ADDR_W-1:0] base_addr;

  assign swap      = xb_q < xa_q;
  assign xl        = swap ? xb_q : xa_q;
  assign xr        = swap ? xa_q : xb_q;
  assign zl        = swap ? zb_q : za_q;
  assign zr        = swap ? za_q : zb_q;
  assign dx        = xr - xl;
  assign dz_neg    = zr < zl;
  assign dz_mag    = dz_neg ? zl - zr : zr - zl;
  assign base_addr = ADDR_W'(line_addr(32'(y_q), 32'(xl), 32'(H_RES)));
  assign div_start = (state_q == S_ORDER) && (dx != '0);
  assign z_pix     = z_acc_q[N-1:FRAC];

  span_div #(.N(N), .D(X_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({dz_mag, {FRAC{1'b0}}}),
    .divisor  (dx),
    .quotient (div_q),
    .done     (div_done)
  );

  // Write strobes are the only outputs qualified by read data: the compare
  // needs zb_rdata of this very CMP cycle, so they are gated from registered
  // state rather than re-registered (which would cost a cycle per pixel and
  // collide with the next read strobe).
  assign wr_hit = (state_q == S_CMP) && (z_pix < zb_rdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      xa_q    <= '0;
      xb_q    <= '0;
      za_q    <= '0;
      zb_q    <= '0;
      y_q     <= '0;
      col_q   <= '0;
      x_q     <= '0;
      xr_q    <= '0;
      neg_q   <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      z_acc_q <= '0;
      slope_q <= '0;
      addr_q  <= '0;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req) begin
          xa_q    <= x_a;
          xb_q    <= x_b;
          za_q    <= z_a;
          zb_q    <= z_b;
          y_q     <= y;
          col_q   <= color;
          ack_q   <= 1'b1;
          state_q <= S_ORDER;
        end
        S_ORDER: begin
          x_q     <= xl;
          xr_q    <= xr;
          neg_q   <= dz_neg;
          addr_q  <= base_addr;
          z_acc_q <= {1'b0, zl, {FRAC{1'b0}}};
          if (dx == '0) begin
            slope_q <= '0;
            rd_q    <= 1'b1;
            state_q <= S_READ;
          end else begin
            state_q <= S_DIV;
          end
        end
        S_DIV: if (div_done) begin
          slope_q <= neg_q ? -{1'b0, div_q} : {1'b0, div_q};
          rd_q    <= 1'b1;
          state_q <= S_READ;
        end
        S_READ: state_q <= S_CMP;
        S_CMP: begin
          if (x_q == xr_q) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            x_q     <= x_q + 1'b1;
            addr_q  <= addr_q + 1'b1;
            z_acc_q <= z_acc_q + slope_q;
            rd_q    <= 1'b1;
            state_q <= S_READ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign zb_rd_en  = rd_q;
  assign zb_addr   = addr_q;
  assign zb_wr_en  = wr_hit;
  assign zb_wdata  = z_pix;
  assign pix_we    = wr_hit;
  assign pix_addr  = addr_q;
  assign pix_color = col_q;

endmodule

// File: tb/tb_span_fill.sv
module tb_span_fill;

  logic        clk = 1'b0, rst = 1'b0, req = 1'b0;
  logic        ack, zb_rd_en, zb_wr_en, pix_we;
  logic [9:0]  x_a = '0, x_b = '0;
  logic [15:0] z_a = '0, z_b = '0, zb_wdata, zb_rdata = '0;
  logic [8:0]  y = '0;
  logic [23:0] color = '0, pix_color;
  logic [18:0] zb_addr, pix_addr;

  int checks = 0, errors = 0;
  logic [15:0] zmem [int];
  logic [34:0] obs [$], expq [$];
  int lat, bad;

  span_fill dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .x_a(x_a), .x_b(x_b),
    .z_a(z_a), .z_b(z_b), .y(y), .color(color), .zb_rd_en(zb_rd_en),
    .zb_addr(zb_addr), .zb_rdata(zb_rdata), .zb_wr_en(zb_wr_en),
    .zb_wdata(zb_wdata), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input int a);
    return zmem.exists(a) ? zmem[a] : 16'hFFFF;
  endfunction

  // Z-buffer read port: data one cycle after the strobe.
  always @(posedge clk) if (zb_rd_en) zb_rdata <= rd(int'(zb_addr));

  // Reference: closed-form interpolation from the span rules.
  task automatic model_span(input int xa, xb, za, zb, yy);
    int xl, xr, zl, zr, dx;
    longint slope, acc;
    expq.delete();
    if (xb < xa) begin xl = xb; xr = xa; zl = zb; zr = za; end
    else begin xl = xa; xr = xb; zl = za; zr = zb; end
    dx = xr - xl;
    if (dx == 0) slope = 0;
    else if (zr >= zl) slope = (longint'(zr - zl) * 256) / dx;
    else slope = -((longint'(zl - zr) * 256) / dx);
    for (int i = 0; i <= dx; i++) begin
      acc = longint'(zl) * 256 + longint'(i) * slope;
      if (int'(acc / 256) < int'(rd(yy * 640 + xl + i)))
        expq.push_back({19'(yy * 640 + xl + i), 16'(acc / 256)});
    end
  endtask

  // Drives one request (called at a negedge) and collects writes until ack=0.
  task automatic run_span(input int xa, xb, za, zb, yy, input logic [23:0] col,
                          input int pulse_at, output int l, output int b);
    obs.delete(); b = 0; l = -1;
    x_a = 10'(xa); x_b = 10'(xb); z_a = 16'(za); z_b = 16'(zb); y = 9'(yy);
    color = col; req = 1'b1;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      req = (c == pulse_at);
      x_a = 10'($urandom); x_b = 10'($urandom); z_a = 16'($urandom);
      z_b = 16'($urandom); y = 9'($urandom_range(0, 479)); color = 24'($urandom);
      if (c == 1 && ack !== 1'b1) b++;
      if (pix_we !== zb_wr_en || (zb_rd_en && zb_wr_en)) b++;
      if (zb_wr_en === 1'b1) begin
        if (pix_addr !== zb_addr || pix_color !== col) b++;
        obs.push_back({zb_addr, zb_wdata});
        zmem[int'(zb_addr)] = zb_wdata;
      end
      if (ack === 1'b0) begin l = c; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({ack, zb_rd_en, zb_wr_en, pix_we} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {ack, zb_rd_en, zb_wr_en, pix_we});
    end
    checks++;
    if (zb_addr !== 0 || zb_wdata !== 0 || pix_addr !== 0 || pix_color !== 0) begin
      errors++; $display("FAIL reset_buses got %h %h %h %h want 0", zb_addr, zb_wdata, pix_addr, pix_color);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input bit swapped);
    zmem.delete();
    if (swapped) run_span(8, 5, 130, 100, 2, 24'h123456, 0, lat, bad);
    else         run_span(5, 8, 100, 130, 2, 24'h123456, 0, lat, bad);
    checks++;
    if (lat !== 35 || bad !== 0) begin
      errors++; $display("FAIL basic_lat swap=%0d got lat %0d bad %0d want 35/0", swapped, lat, bad);
    end
    checks++;
    if (obs.size() !== 4) begin
      errors++; $display("FAIL basic_count swap=%0d got %0d want 4", swapped, obs.size());
    end else for (int i = 0; i < 4; i++) begin
      logic [34:0] w;
      w = {19'(1285 + i), 16'(100 + 10 * i)};
      checks++;
      if (obs[i] !== w) begin
        errors++; $display("FAIL basic_wr%0d swap=%0d got %h want %h", i, swapped, obs[i], w);
      end
    end
  endtask

  task automatic test_single;
    for (int s = 50; s <= 51; s++) begin
      zmem.delete(); zmem[0] = 16'(s);
      run_span(0, 0, 50, 50, 0, 24'hABCDEF, 0, lat, bad);
      checks++;
      if (lat !== 4 || bad !== 0) begin
        errors++; $display("FAIL single_lat stored=%0d got %0d bad %0d want 4/0", s, lat, bad);
      end
      checks++;
      if (obs.size() !== s - 50 || (s == 51 && obs[0] !== {19'd0, 16'd50})) begin
        errors++; $display("FAIL single_wr stored=%0d got %0d writes want %0d", s, obs.size(), s - 50);
      end
    end
  endtask

  task automatic test_negative;
    int want [4] = '{400, 300, 100, 0};
    int wa [4] = '{0, 1, 3, 4};
    zmem.delete(); zmem[2] = 16'd150;
    run_span(0, 4, 400, 0, 0, 24'h00FF00, 0, lat, bad);
    checks++;
    if (lat !== 37 || bad !== 0 || obs.size() !== 4) begin
      errors++; $display("FAIL neg_span got lat %0d bad %0d n %0d want 37/0/4", lat, bad, obs.size());
    end else for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[i] !== {19'(wa[i]), 16'(want[i])}) begin
        errors++; $display("FAIL neg_wr%0d got %h want %h", i, obs[i], {19'(wa[i]), 16'(want[i])});
      end
    end
  endtask

  // Random spans (with random Z presets) and optional mid-span req pulses.
  task automatic test_random(input int n, input bit pulse);
    int xa, xb, za, zb, yy, dx, pa;
    for (int k = 0; k < n; k++) begin
      xa = $urandom_range(0, 639); xb = $urandom_range(0, 639);
      za = $urandom_range(0, 65535); zb = $urandom_range(0, 65535);
      yy = $urandom_range(0, 479);
      dx = (xa > xb) ? xa - xb : xb - xa;
      for (int p = 0; p < 6; p++)
        zmem[yy * 640 + $urandom_range(0, 639)] = 16'($urandom);
      pa = pulse ? $urandom_range(2, 2 * dx + 26) : 0;
      model_span(xa, xb, za, zb, yy);
      run_span(xa, xb, za, zb, yy, 24'($urandom), pa, lat, bad);
      checks++;
      if (lat !== (dx == 0 ? 4 : 2 * dx + 29) || bad !== 0) begin
        errors++; $display("FAIL rand_lat k=%0d dx=%0d got %0d bad %0d", k, dx, lat, bad);
      end
      checks++;
      if (obs !== expq) begin
        errors++; $display("FAIL rand_wr k=%0d got %0d writes want %0d", k, obs.size(), expq.size());
      end
    end
  endtask

  // Reset while busy: outputs clear at once, nothing written afterwards.
  task automatic test_reset_mid(input bit in_cmp);
    int wr = 0, c = 0;
    zmem.delete();
    x_a = 10'd20; x_b = 10'd22; z_a = 16'd5; z_b = 16'd9; y = 9'd3; req = 1'b1;
    @(negedge clk); req = 1'b0;
    if (in_cmp) while (zb_wr_en !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    else repeat (9) @(negedge clk);
    checks++;
    if (ack !== 1'b1 || c >= 100) begin
      errors++; $display("FAIL rstmid_busy cmp=%0d got ack %b want 1", in_cmp, ack);
    end
    #1 rst = 1'b0; #1;
    checks++;
    if ({ack, zb_rd_en, zb_wr_en, pix_we} !== 4'b0 || zb_addr !== 0 || zb_wdata !== 0) begin
      errors++; $display("FAIL rstmid_out cmp=%0d got %b %h %h want 0", in_cmp,
                         {ack, zb_rd_en, zb_wr_en, pix_we}, zb_addr, zb_wdata);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      if (zb_wr_en === 1'b1 || ack === 1'b1) wr++;
    end
    checks++;
    if (wr !== 0) begin
      errors++; $display("FAIL rstmid_quiet cmp=%0d got %0d active cycles want 0", in_cmp, wr);
    end
    model_span(20, 22, 5, 9, 3);
    run_span(20, 22, 5, 9, 3, 24'h777777, 0, lat, bad);
    checks++;
    if (lat !== 33 || bad !== 0 || obs !== expq) begin
      errors++; $display("FAIL rstmid_after cmp=%0d got lat %0d n %0d want 33 n %0d",
                         in_cmp, lat, obs.size(), expq.size());
    end
  endtask

  task automatic test_back_to_back;
    int la;
    zmem.delete();
    run_span(5, 8, 100, 130, 2, 24'h111111, 0, la, bad);
    // Still at the negedge where ack fell: issue the next req in this cycle.
    model_span(0, 4, 10, 50, 1);
    run_span(0, 4, 10, 50, 1, 24'h222222, 0, lat, bad);
    checks++;
    if (la !== 35 || lat !== 37 || bad !== 0) begin
      errors++; $display("FAIL b2b_lat got %0d/%0d bad %0d want 35/37/0", la, lat, bad);
    end
    checks++;
    if (obs !== expq || obs.size() !== 5) begin
      errors++; $display("FAIL b2b_wr got %0d writes want %0d", obs.size(), expq.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_single();
    test_negative();
    zmem.delete();
    test_random(8, 1'b0);
    test_random(4, 1'b1);
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
